multi_counter: RTL

//  Parametrised multi-channel up/down event counter; successor to the single-channel counter.

---
 rtl/multi_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/multi_counter.sv
// ============================================================================
// Module   : multi_counter
// Purpose  : Multi-channel up/down event counter with wrap/saturate modes,
//            sticky overflow flags and a read-and-clear port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_counter #(
  parameter int NCH_P   = 4,
  parameter int WIDTH_P = 8,
  parameter int INC_W_P = 4,
  parameter int SAT_P   = 0,
  parameter int SEL_W_P = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH_P-1:0]           en,
  input  logic [NCH_P-1:0]           dir,
  input  logic [NCH_P*INC_W_P-1:0]   inc,
  input  logic [NCH_P-1:0]           clr,
  input  logic [SEL_W_P-1:0]         rd_sel,
  input  logic                       rd_clr,
  output logic [NCH_P*WIDTH_P-1:0]   val,
  output logic [NCH_P-1:0]           non_zero,
  output logic [NCH_P-1:0]           ovf,
  output logic [WIDTH_P-1:0]         rd_val,
  output logic                       rd_vld
);

  logic [WIDTH_P-1:0] r_val [NCH_P];
  logic               r_ovf [NCH_P];
  logic [WIDTH_P-1:0] r_rd_val;
  logic               r_rd_vld;
  logic [WIDTH_P-1:0] w_rd_data;

  // Returns {event, next value}; the extra top bit is carry (up) or borrow (down).
  function automatic logic [WIDTH_P:0] f_step(input logic [WIDTH_P-1:0] x,
                                              input logic               up,
                                              input logic [INC_W_P-1:0] d);
    logic [WIDTH_P:0] s;
    logic [WIDTH_P:0] dz;
    dz = {{(WIDTH_P+1-INC_W_P){1'b0}}, d};
    s  = up ? ({1'b0, x} + dz) : ({1'b0, x} - dz);
    if (s[WIDTH_P] && (SAT_P != 0)) begin
      s[WIDTH_P-1:0] = up ? {WIDTH_P{1'b1}} : {WIDTH_P{1'b0}};
    end
    return s;
  endfunction

  generate
    for (genvar i = 0; i < NCH_P; i++) begin : g_ch
      logic             w_hit;
      logic [WIDTH_P:0] w_nxt;

      assign w_hit = rd_clr && (rd_sel == SEL_W_P'(i));
      // A read-and-clear restarts from zero so a same-cycle event is kept.
      assign w_nxt = f_step(w_hit ? {WIDTH_P{1'b0}} : r_val[i], dir[i],
                            inc[i*INC_W_P +: INC_W_P]);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_val[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (clr[i]) begin
          r_val[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_hit) begin
          r_val[i] <= en[i] ? w_nxt[WIDTH_P-1:0] : {WIDTH_P{1'b0}};
          r_ovf[i] <= en[i] & w_nxt[WIDTH_P];
        end else if (en[i]) begin
          r_val[i] <= w_nxt[WIDTH_P-1:0];
          r_ovf[i] <= r_ovf[i] | w_nxt[WIDTH_P];
        end
      end

      assign val[i*WIDTH_P +: WIDTH_P] = r_val[i];
      assign non_zero[i]               = |r_val[i];
      assign ovf[i]                    = r_ovf[i];
    end
  endgenerate

  // Out-of-range selects and channels cleared this cycle read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NCH_P; i++) begin
      if ((rd_sel == SEL_W_P'(i)) && !clr[i]) begin
        w_rd_data = r_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_val <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= rd_clr;
      if (rd_clr) begin
        r_rd_val <= w_rd_data;
      end
    end
  end

  assign rd_val = r_rd_val;
  assign rd_vld = r_rd_vld;

endmodule

`default_nettype wire
